// File: rtl/sm_reg_dump_pkg.sv
// Shared types and constants for the register-file serial dump engine.
package sm_reg_dump_pkg;

  localparam int unsigned ADDR_W        = 5;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned BAUD_CNT_W    = 16;
  localparam int unsigned SETTLE_CNT_W  = 16;
  localparam int unsigned BYTES_PER_REG = 5;
  localparam logic [7:0]  HDR_BYTE      = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CAP    = 3'd3,
    ST_SEND   = 3'd4,
    ST_DRAIN  = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  // Byte order on the wire for one register: address, then data MSB first.
  function automatic logic [7:0] byte_sel(input logic [DATA_W-1:0] word,
                                          input logic [ADDR_W-1:0] addr,
                                          input logic [2:0]        idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = {3'b000, addr};
      3'd1:    b = word[31:24];
      3'd2:    b = word[23:16];
      3'd3:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/sm_uart_tx.sv
// UART 8N1 transmitter with a valid/ready byte handshake and back-to-back framing.
module sm_uart_tx
  import sm_reg_dump_pkg::*;
#(
  parameter int unsigned BAUD_DIV = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid,
  input  logic [7:0] data,
  output logic       ready,
  output logic       tx
);

  localparam logic [BAUD_CNT_W-1:0] BAUD_LAST     = BAUD_CNT_W'(BAUD_DIV - 1);
  localparam logic                  ONE_CYCLE_BIT = (BAUD_DIV == 1);

  logic [8:0]            frame;
  logic [BAUD_CNT_W-1:0] baud_cnt;
  logic [3:0]            bit_cnt;
  logic                  active;

  // bit_cnt: 0 = start bit, 1..8 = data bits, 9 = stop bit.
  // ready is raised so that it is high during the last cycle of the stop bit,
  // letting the next start bit follow with no idle cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx       <= 1'b1;
      ready    <= 1'b1;
      active   <= 1'b0;
      frame    <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else if (valid && ready) begin
      tx       <= 1'b0;
      frame    <= {1'b1, data};
      bit_cnt  <= 4'd0;
      baud_cnt <= BAUD_LAST;
      active   <= 1'b1;
      ready    <= 1'b0;
    end else if (active) begin
      if (baud_cnt == '0) begin
        if (bit_cnt == 4'd9) begin
          active <= 1'b0;
          tx     <= 1'b1;
          ready  <= 1'b1;
        end else begin
          tx       <= frame[0];
          frame    <= {1'b1, frame[8:1]};
          bit_cnt  <= bit_cnt + 4'd1;
          baud_cnt <= BAUD_LAST;
          ready    <= (bit_cnt == 4'd8) && ONE_CYCLE_BIT;
        end
      end else begin
        baud_cnt <= baud_cnt - BAUD_CNT_W'(1);
        ready    <= (bit_cnt == 4'd9) && (baud_cnt == BAUD_CNT_W'(1));
      end
    end
  end

endmodule

// File: rtl/sm_reg_dump.sv
// Walks the CPU debug register range and streams header + per-register bytes over UART.
module sm_reg_dump
  import sm_reg_dump_pkg::*;
#(
  parameter int unsigned BAUD_DIV  = 434,
  parameter int unsigned REG_FIRST = 0,
  parameter int unsigned REG_LAST  = 31,
  parameter int unsigned SETTLE    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] regAddr,
  input  logic [DATA_W-1:0] regData,
  output logic              tx
);

  localparam logic [ADDR_W-1:0]       ADDR_FIRST  = ADDR_W'(REG_FIRST);
  localparam logic [ADDR_W-1:0]       ADDR_LAST   = ADDR_W'(REG_LAST);
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE - 1);
  localparam logic [2:0]              BYTE_LAST   = 3'(BYTES_PER_REG - 1);

  state_e                  state;
  logic [SETTLE_CNT_W-1:0] settle_cnt;
  logic [2:0]              byte_idx;
  logic [DATA_W-1:0]       shadow;
  logic                    tx_valid;
  logic                    tx_ready;
  logic [7:0]              tx_byte_c;
  logic                    xfer_c;

  assign xfer_c    = tx_valid & tx_ready;
  assign tx_byte_c = (state == ST_HDR) ? HDR_BYTE : byte_sel(shadow, regAddr, byte_idx);

  // Settling and capture overlap the byte on the wire, so frames stay back to back.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      regAddr    <= ADDR_FIRST;
      settle_cnt <= '0;
      byte_idx   <= '0;
      shadow     <= '0;
      tx_valid   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state    <= ST_HDR;
            busy     <= 1'b1;
            tx_valid <= 1'b1;
          end
        end
        ST_HDR: begin
          if (xfer_c) begin
            tx_valid   <= 1'b0;
            regAddr    <= ADDR_FIRST;
            settle_cnt <= '0;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= ST_CAP;
          end else begin
            settle_cnt <= settle_cnt + SETTLE_CNT_W'(1);
          end
        end
        ST_CAP: begin
          shadow   <= regData;
          byte_idx <= 3'd0;
          tx_valid <= 1'b1;
          state    <= ST_SEND;
        end
        ST_SEND: begin
          if (xfer_c) begin
            if (byte_idx == BYTE_LAST) begin
              tx_valid <= 1'b0;
              if (regAddr == ADDR_LAST) begin
                state <= ST_DRAIN;
              end else begin
                regAddr    <= regAddr + ADDR_W'(1);
                settle_cnt <= '0;
                state      <= ST_SETTLE;
              end
            end else begin
              byte_idx <= byte_idx + 3'd1;
            end
          end
        end
        ST_DRAIN: begin
          // Transmitter ready again means the final stop bit is in its last cycle.
          if (tx_ready) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  sm_uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_tx (
    .clk  (clk),
    .rst_n(rst_n),
    .valid(tx_valid),
    .data (tx_byte_c),
    .ready(tx_ready),
    .tx   (tx)
  );

endmodule

// File: tb/tb_sm_reg_dump.sv
// Directed bench for sm_reg_dump: three configurations, UART decode and byte/timing checks.
module tb_sm_reg_dump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  starts;
  logic        busy_a, busy_b, busy_c, done_a, done_b, done_c, tx_a, tx_b, tx_c;
  logic [4:0]  regAddr_a, regAddr_b, regAddr_c;
  logic [31:0] regData_a, regData_b, regData_c;
  logic        mode_t4;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int start_cyc = 0;

  localparam int BAUDS [3] = '{4, 7, 1};
  localparam logic [7:0] EXP_T1 [11] = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h02,
                                         8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
  localparam logic [7:0] EXP_T4 [11] = '{8'hA5, 8'h02, 8'h5E, 8'hED, 8'h00, 8'h02,
                                         8'h03, 8'h5E, 8'hED, 8'h00, 8'h03};
  localparam logic [7:0] EXP_T2 [11] = '{8'hA5, 8'h1E, 8'hA0, 8'hB0, 8'hC0, 8'h1E,
                                         8'h1F, 8'hA0, 8'hB0, 8'hC0, 8'h1F};
  localparam logic [7:0] EXP_T6 [11] = '{8'hA5, 8'h1F, 8'h4B, 8'h3C, 8'h2D, 8'h1E,
                                         8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sm_reg_dump #(.BAUD_DIV(4), .REG_FIRST(2), .REG_LAST(3), .SETTLE(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(starts[0]), .busy(busy_a), .done(done_a),
    .regAddr(regAddr_a), .regData(regData_a), .tx(tx_a));
  sm_reg_dump #(.BAUD_DIV(7), .REG_FIRST(30), .REG_LAST(31), .SETTLE(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(starts[1]), .busy(busy_b), .done(done_b),
    .regAddr(regAddr_b), .regData(regData_b), .tx(tx_b));
  sm_reg_dump #(.BAUD_DIV(1), .REG_FIRST(31), .REG_LAST(31), .SETTLE(4)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .start(starts[2]), .busy(busy_c), .done(done_c),
    .regAddr(regAddr_c), .regData(regData_c), .tx(tx_c));

  // Register models; in T4 mode channel A's data depends on cycles since the address changed.
  logic [4:0] addr_prev = 5'd0;
  logic [7:0] age_q = 8'd0;
  logic [7:0] age_eff;
  always @(posedge clk) begin
    addr_prev <= regAddr_a;
    if (regAddr_a != addr_prev) age_q <= 8'd1;
    else if (age_q != 8'd255) age_q <= age_q + 8'd1;
  end
  assign age_eff = (regAddr_a != addr_prev) ? 8'd0 : age_q;
  assign regData_a = !mode_t4 ? (32'h1122_3300 | {27'b0, regAddr_a}) :
                     (age_eff == 8'd0) ? (32'hBAD0_0000 | {27'b0, regAddr_a}) :
                     (age_eff <= 8'd6) ? (32'h5EED_0000 | {27'b0, regAddr_a}) :
                                         (32'hF00D_0000 | {27'b0, regAddr_a});
  assign regData_b = 32'hA0B0_C000 | {27'b0, regAddr_b};
  assign regData_c = 32'h4B3C_2D1E;

  // UART receivers and done monitors, sampled on the falling edge.
  logic [2:0] txs, dones, busys;
  assign txs   = {tx_c, tx_b, tx_a};
  assign dones = {done_c, done_b, done_a};
  assign busys = {busy_c, busy_b, busy_a};

  logic       rx_busy   [3] = '{1'b0, 1'b0, 1'b0};
  logic       rx_lvl    [3] = '{1'b1, 1'b1, 1'b1};
  logic       prev_busy [3] = '{1'b0, 1'b0, 1'b0};
  logic [7:0] rx_sh     [3] = '{8'h00, 8'h00, 8'h00};
  int         rx_cnt    [3] = '{0, 0, 0};
  int         rx_n      [3] = '{0, 0, 0};
  int         rx_err    [3] = '{0, 0, 0};
  int         done_cnt  [3] = '{0, 0, 0};
  int         done_bad  [3] = '{0, 0, 0};
  logic [7:0] rx_buf    [3][256];
  int         rx_start  [3][256];

  always @(negedge clk) begin
    for (int c = 0; c < 3; c++) begin
      prev_busy[c] <= busys[c];
      if (dones[c]) begin
        done_cnt[c] <= done_cnt[c] + 1;
        if (busys[c] || !prev_busy[c]) done_bad[c] <= done_bad[c] + 1;
      end
      if (!rst_n) begin
        rx_busy[c] <= 1'b0;
      end else if (!rx_busy[c]) begin
        if (!txs[c]) begin
          rx_busy[c] <= 1'b1;
          rx_cnt[c]  <= 1;
          rx_lvl[c]  <= 1'b0;
          rx_start[c][rx_n[c]] <= cyc;
        end
      end else begin
        if (rx_cnt[c] % BAUDS[c] == 0) begin
          rx_lvl[c] <= txs[c];
          if (rx_cnt[c] < 9 * BAUDS[c]) rx_sh[c] <= {txs[c], rx_sh[c][7:1]};
          else if (!txs[c]) rx_err[c] <= rx_err[c] + 1;
        end else if (txs[c] != rx_lvl[c]) begin
          rx_err[c] <= rx_err[c] + 1;
        end
        if (rx_cnt[c] == 10 * BAUDS[c] - 1) begin
          rx_buf[c][rx_n[c]] <= rx_sh[c];
          rx_n[c]    <= rx_n[c] + 1;
          rx_busy[c] <= 1'b0;
        end else begin
          rx_cnt[c] <= rx_cnt[c] + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input int c);
    @(negedge clk);
    starts[c] = 1'b1;
    start_cyc = cyc;
    @(negedge clk);
    starts[c] = 1'b0;
  endtask

  task automatic wait_done(input int c, input string tag);
    int prev;
    int n;
    prev = done_cnt[c];
    n = 0;
    while (done_cnt[c] == prev && n < 3000) begin
      @(posedge clk);
      n++;
    end
    check(tag, 32'(done_cnt[c] - prev), 32'd1);
  endtask

  task automatic check_dump(input int c, input int base, input int n,
                            input logic [7:0] exp [11], input string tag);
    int bad_gap;
    bad_gap = 0;
    check({tag, "_count"}, 32'(rx_n[c] - base), 32'(n));
    for (int i = 0; i < n; i++)
      check($sformatf("%s_byte%0d", tag, i), {24'b0, rx_buf[c][base + i]}, {24'b0, exp[i]});
    for (int i = 1; i < n; i++)
      if (rx_start[c][base + i] - rx_start[c][base + i - 1] != 10 * BAUDS[c]) bad_gap++;
    check({tag, "_gaps"}, 32'(bad_gap), 32'd0);
    check({tag, "_framing"}, 32'(rx_err[c]), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    logic low_seen;
    rst_n   = 1'b0;
    starts  = 3'b000;
    mode_t4 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx", {31'b0, tx_a}, 32'd1);
    check("rst_busy", {31'b0, busy_a}, 32'd0);
    check("rst_done", {31'b0, done_a}, 32'd0);
    check("rst_addr_a", {27'b0, regAddr_a}, 32'd2);
    check("rst_addr_c", {27'b0, regAddr_c}, 32'd31);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // T1: basic dump
    pulse(0);
    wait_done(0, "t1_done");
    repeat (5) @(posedge clk);
    check_dump(0, 0, 11, EXP_T1, "t1");
    check("t1_done_busy", 32'(done_bad[0]), 32'd0);
    check("t1_busy_after", {31'b0, busy_a}, 32'd0);

    // T3: start during byte 3 is ignored
    base = rx_n[0];
    pulse(0);
    n = 0;
    while (rx_n[0] < base + 3 && n < 1000) begin @(posedge clk); n++; end
    check("t3_reach_byte3", 32'(rx_n[0] >= base + 3), 32'd1);
    repeat (6) @(posedge clk);
    check("t3_busy_mid", {31'b0, busy_a}, 32'd1);
    pulse(0);
    wait_done(0, "t3_done");
    repeat (200) @(posedge clk);
    check_dump(0, base, 11, EXP_T1, "t3");
    check("t3_single_done", 32'(done_cnt[0]), 32'd2);

    // T4: capture happens SETTLE cycles after the address change
    base = rx_n[0];
    mode_t4 = 1'b1;
    pulse(0);
    wait_done(0, "t4_done");
    repeat (5) @(posedge clk);
    mode_t4 = 1'b0;
    check_dump(0, base, 11, EXP_T4, "t4");

    // T5: async reset in a low data bit of byte 5 (0x03, data bit 2)
    base = rx_n[0];
    pulse(0);
    n = 0;
    do begin @(posedge clk); n++; end
    while (!(rx_busy[0] && rx_n[0] == base + 5 && rx_cnt[0] == 13) && n < 1000);
    #2;
    check("t5_pre_tx", {31'b0, tx_a}, 32'd0);
    check("t5_pre_addr", {27'b0, regAddr_a}, 32'd3);
    rst_n = 1'b0;
    #1;
    check("t5_rst_tx", {31'b0, tx_a}, 32'd1);
    check("t5_rst_busy", {31'b0, busy_a}, 32'd0);
    check("t5_rst_addr", {27'b0, regAddr_a}, 32'd2);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    low_seen = 1'b0;
    repeat (50) begin @(negedge clk); if (!tx_a) low_seen = 1'b1; end
    check("t5_idle_high", {31'b0, low_seen}, 32'd0);
    check("t5_truncated", 32'(rx_n[0] - base), 32'd5);
    base = rx_n[0];
    pulse(0);
    wait_done(0, "t5_done");
    repeat (5) @(posedge clk);
    check_dump(0, base, 11, EXP_T1, "t5");

    // T2: bit timing at BAUD_DIV=7 and start latency
    pulse(1);
    check("t2_latency", 32'(rx_start[1][0] - start_cyc <= 2), 32'd1);
    wait_done(1, "t2_done");
    repeat (5) @(posedge clk);
    check_dump(1, 0, 11, EXP_T2, "t2");
    check("t2_done_busy", 32'(done_bad[1]), 32'd0);

    // T6: BAUD_DIV=1, single register 31
    pulse(2);
    wait_done(2, "t6_done");
    repeat (5) @(posedge clk);
    check_dump(2, 0, 6, EXP_T6, "t6");
    check("t6_done_busy", 32'(done_bad[2]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
